// File: rtl/link_pkg.sv
// Shared link-layer constants, types and the CRC-8 step function used by the
// transmitter, receiver and framer.
package link_pkg;

    localparam logic [7:0] PID_DATA  = 8'h3c;
    localparam logic [7:0] PID_READY = 8'ha5;
    localparam logic [7:0] PID_ACK   = 8'hd2;
    localparam logic [7:0] PID_NAK   = 8'h5a;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    localparam int unsigned ACK_TIMEOUT = 256;
    localparam int unsigned MAX_RETRIES = 3;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_IGNORED = 2'b01;
    localparam logic [1:0] ERR_FAIL    = 2'b10;
    localparam logic [1:0] ERR_NONE    = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCrc,
        StArm,
        StBusy
    } framer_state_e;

    // One MSB-first step of x^8+x^2+x+1, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 register (poly 0x07, init 0); clear has priority over enable.
module crc8_serial
    import link_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/tx_framer.sv
// Frames 32-bit payload words as {PID_DATA, word, crc8}, hands them to the
// transmitter and tracks per-packet outcome and saturating statistics.
module tx_framer
    import link_pkg::*;
#(
    parameter int unsigned N_PKT          = 48,
    parameter int unsigned N_DATA         = 32,
    parameter int unsigned RESEND_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_DATA-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N_PKT-1:0]  tx_data,
    output logic              tx_start,
    input  logic              tx_avail,
    input  logic [1:0]        tx_err_code,
    output logic              done,
    output logic              fail,
    output logic [15:0]       sent_count,
    output logic [15:0]       fail_count
);

    localparam int unsigned CNT_W = $clog2(N_DATA);

    framer_state_e     state_q;
    logic [N_DATA-1:0] word_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [7:0]        crc_q;
    logic              crc_clr;
    logic              crc_en;
    logic              crc_bit;
    logic              last_bit;

    always_comb begin
        in_ready = (state_q == StIdle);
        tx_start = (state_q == StArm) && tx_avail;
        done     = (state_q == StBusy) && (tx_err_code == ERR_OK);
        fail     = (state_q == StBusy) && (tx_err_code == ERR_FAIL);
        crc_clr  = in_ready && in_valid;
        crc_en   = (state_q == StCrc);
        crc_bit  = word_q[CNT_W'(N_DATA - 1) - bit_cnt_q];
        last_bit = (bit_cnt_q == CNT_W'(N_DATA - 1));
    end

    crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (crc_bit),
        .crc    (crc_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            word_q     <= '0;
            bit_cnt_q  <= '0;
            tx_data    <= '0;
            sent_count <= 16'h0000;
            fail_count <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        word_q    <= in_data;
                        bit_cnt_q <= '0;
                        state_q   <= StCrc;
                    end
                end
                StCrc: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        // Fold in the final bit here so tx_data is valid on ARM entry.
                        tx_data <= {PID_DATA, word_q, crc8_step(crc_q, crc_bit)};
                        state_q <= StArm;
                    end
                end
                StArm: begin
                    if (tx_avail) begin
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    case (tx_err_code)
                        ERR_OK: begin
                            if (sent_count != 16'hFFFF) begin
                                sent_count <= sent_count + 16'd1;
                            end
                            state_q <= StIdle;
                        end
                        ERR_FAIL: begin
                            if (fail_count != 16'hFFFF) begin
                                fail_count <= fail_count + 16'd1;
                            end
                            state_q <= (RESEND_ON_FAIL != 0) ? StArm : StIdle;
                        end
                        default: state_q <= StBusy;
                    endcase
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: one drop-on-fail and one resend-on-fail instance
// share all inputs and run in lockstep except after a failed packet.
module tb_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        tx_avail;
    logic [1:0]  tx_err_code;

    logic        in_ready0, tx_start0, done0, fail0;
    logic [47:0] tx_data0;
    logic [15:0] sent0, failc0;
    logic        in_ready1, tx_start1, done1, fail1;
    logic [47:0] tx_data1;
    logic [15:0] sent1, failc1;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] sent_exp0, fail_exp0, sent_exp1, fail_exp1;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  crc;
        int          nwait;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    tx_framer #(.RESEND_ON_FAIL(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready0),
        .tx_data     (tx_data0),
        .tx_start    (tx_start0),
        .tx_avail    (tx_avail),
        .tx_err_code (tx_err_code),
        .done        (done0),
        .fail        (fail0),
        .sent_count  (sent0),
        .fail_count  (failc0)
    );

    tx_framer #(.RESEND_ON_FAIL(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready1),
        .tx_data     (tx_data1),
        .tx_start    (tx_start1),
        .tx_avail    (tx_avail),
        .tx_err_code (tx_err_code),
        .done        (done1),
        .fail        (fail1),
        .sent_count  (sent1),
        .fail_count  (failc1)
    );

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_counts(input string nm);
        chk({nm, " sent0"}, 48'(sent0), 48'(sent_exp0));
        chk({nm, " failc0"}, 48'(failc0), 48'(fail_exp0));
        chk({nm, " sent1"}, 48'(sent1), 48'(sent_exp1));
        chk({nm, " failc1"}, 48'(failc1), 48'(fail_exp1));
    endtask

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic accept(input logic [31:0] word);
        @(negedge clk);
        in_data  = word;
        in_valid = 1'b1;
        #1;
        chk("accept in_ready", 48'(in_ready0), 48'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Cycle index (1 = first cycle after the accept edge) at which tx_start is seen.
    task automatic wait_start(output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            #1;
            if (tx_start0) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic busy_resolve(input logic [1:0] code, input int nwait);
        int quiet_bad;
        quiet_bad = 0;
        for (int k = 0; k < nwait; k++) begin
            @(negedge clk);
            tx_err_code = k[0] ? 2'b01 : 2'b11;
            #1;
            if (done0 || fail0 || in_ready0 || tx_start0) quiet_bad++;
        end
        if (nwait > 0) chk("busy wait quiet", 48'(quiet_bad), 48'd0);
        @(negedge clk);
        tx_err_code = code;
        #1;
        chk("done0", 48'(done0), 48'(code == 2'b00));
        chk("fail0", 48'(fail0), 48'(code == 2'b10));
        chk("done1", 48'(done1), 48'(code == 2'b00));
        @(negedge clk);
        tx_err_code = 2'b11;
        #1;
    endtask

    task automatic run_packet(input logic [31:0] word, input logic [7:0] crc, input int nwait);
        int lat;
        accept(word);
        wait_start(lat);
        chk("start latency", 48'(lat), 48'd33);
        chk("tx_data0", tx_data0, {8'h3c, word, crc});
        chk("tx_data1", tx_data1, {8'h3c, word, crc});
        busy_resolve(2'b00, nwait);
        sent_exp0 = sat_inc(sent_exp0);
        sent_exp1 = sat_inc(sent_exp1);
        chk("idle in_ready", 48'(in_ready0), 48'd1);
        chk_counts("after packet");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bad;
        vecs[0] = '{32'h0000_0000, 8'h00, 1};
        vecs[1] = '{32'h0000_0001, 8'h07, 0};
        vecs[2] = '{32'h0000_0080, 8'h89, 2};
        vecs[3] = '{32'h0000_0100, 8'h15, 3};
        vecs[4] = '{32'h0000_0002, 8'h0e, 1};
        vecs[5] = '{32'h0000_0003, 8'h09, 0};
        sent_exp0 = 16'h0; fail_exp0 = 16'h0;
        sent_exp1 = 16'h0; fail_exp1 = 16'h0;

        // Reset values
        rst = 1'b1; in_data = '0; in_valid = 1'b0; tx_avail = 1'b0; tx_err_code = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready", 48'(in_ready0), 48'd1);
        chk("rst tx_start", 48'(tx_start0), 48'd0);
        chk("rst tx_data", tx_data0, 48'd0);
        chk("rst done/fail", 48'({done0, fail0}), 48'd0);
        chk_counts("rst");
        @(negedge clk);
        rst = 1'b0;

        // CRC vectors, zero payload first
        tx_avail = 1'b1;
        for (int v = 0; v < 6; v++) begin
            run_packet(vecs[v].word, vecs[v].crc, vecs[v].nwait);
        end

        // Stalled transmitter, stale err codes and a competing word during ARM
        tx_avail = 1'b0;
        accept(32'h0000_0080);
        bad = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            #1;
            if (in_ready0 || tx_start0) bad++;
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_data     = 32'hdead_beef;
            tx_err_code = i[0] ? 2'b10 : 2'b00;
            #1;
            if (tx_start0 || done0 || fail0 || in_ready0 || tx_start1 || done1) bad++;
            if (tx_data0 !== 48'h3c_0000_0080_89) bad++;
        end
        chk("stall quiet", 48'(bad), 48'd0);
        @(negedge clk);
        in_valid = 1'b0;
        tx_err_code = 2'b11;
        tx_avail = 1'b1;
        #1;
        chk("stall release tx_start", 48'(tx_start0), 48'd1);
        chk("stall tx_data stable", tx_data0, 48'h3c_0000_0080_89);
        busy_resolve(2'b00, 1);
        sent_exp0 = sat_inc(sent_exp0);
        sent_exp1 = sat_inc(sent_exp1);
        chk_counts("stall");

        // Failure: instance 0 drops, instance 1 re-arms with the same packet
        accept(32'h0000_0001);
        wait_start(lat);
        chk("fail start latency", 48'(lat), 48'd33);
        busy_resolve(2'b10, 0);
        fail_exp0 = sat_inc(fail_exp0);
        fail_exp1 = sat_inc(fail_exp1);
        chk("drop in_ready0", 48'(in_ready0), 48'd1);
        chk("drop tx_start0", 48'(tx_start0), 48'd0);
        chk("resend tx_start1", 48'(tx_start1), 48'd1);
        chk("resend tx_data1", tx_data1, 48'h3c_0000_0001_07);
        chk_counts("fail");
        @(negedge clk);
        tx_err_code = 2'b00;
        #1;
        chk("resend done1", 48'(done1), 48'd1);
        chk("idle ignores err done0", 48'(done0), 48'd0);
        @(negedge clk);
        tx_err_code = 2'b11;
        #1;
        sent_exp1 = sat_inc(sent_exp1);
        chk_counts("resend");

        // Saturation of sent_count
        @(negedge clk);
        force dut0.sent_count = 16'hFFFF;
        @(negedge clk);
        release dut0.sent_count;
        #1;
        sent_exp0 = 16'hFFFF;
        chk("preload sent0", 48'(sent0), 48'hFFFF);
        run_packet(32'h0000_0000, 8'h00, 0);

        // Reset in BUSY with an ack presented
        accept(32'h0000_0002);
        wait_start(lat);
        chk("rst-test start latency", 48'(lat), 48'd33);
        @(negedge clk);
        tx_err_code = 2'b00;
        rst = 1'b1;
        #1;
        chk("mid rst done/fail", 48'({done0, fail0, done1, fail1}), 48'd0);
        chk("mid rst tx_start", 48'(tx_start0), 48'd0);
        chk("mid rst tx_data", tx_data0, 48'd0);
        chk("mid rst in_ready", 48'(in_ready0), 48'd1);
        sent_exp0 = 16'h0; fail_exp0 = 16'h0;
        sent_exp1 = 16'h0; fail_exp1 = 16'h0;
        chk_counts("mid rst");
        @(negedge clk);
        rst = 1'b0;
        tx_err_code = 2'b11;
        run_packet(32'h0000_0100, 8'h15, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
